// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the branch-prediction resolver and BTB write port
package bp_pkg;
    localparam int PC_W = 64;

    function automatic int TAG_W(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pred_dest;
        logic            pred_valid;
        logic            pred_uncond;
        logic            resolved;
        logic            taken;
        logic [PC_W-1:0] dest;
        logic            uncond;
        logic            valid;
    } bp_entry_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] dest;
        logic            uncond;
    } bp_update_t;
endpackage

// File: rtl/bp_resolver.sv
// bp_resolver: tracks fetch predictions in order, accepts out-of-order resolutions, retires in order driving BTB update and mispredict redirect
// Ports: clk/clkEn/rst control; alloc* record a fetch prediction (allocTag returns its tag);
// resolve* deliver execute outcomes by tag; flush discards everything; update* is the BTB
// write strobe; redirect* is the front-end redirect; count is the queue occupancy.
module bp_resolver
    import bp_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int INST_BYTES = 4
) (
    input  logic                     clk,
    input  logic                     clkEn,
    input  logic                     rst,
    input  logic                     allocValid,
    output logic                     allocReady,
    input  logic [PC_W-1:0]          allocPc,
    input  logic [PC_W-1:0]          allocPredDest,
    input  logic                     allocPredValid,
    input  logic                     allocPredUncond,
    output logic [TAG_W(DEPTH)-1:0]  allocTag,
    input  logic                     resolveValid,
    input  logic [TAG_W(DEPTH)-1:0]  resolveTag,
    input  logic                     resolveTaken,
    input  logic                     resolveUncond,
    input  logic [PC_W-1:0]          resolveDest,
    input  logic                     flush,
    output logic                     update,
    output logic [PC_W-1:0]          updatePc,
    output logic [PC_W-1:0]          updateDest,
    output logic                     updateUncond,
    output logic                     redirectValid,
    output logic [PC_W-1:0]          redirectPc,
    output logic [TAG_W(DEPTH):0]    count
);
    localparam int TW = TAG_W(DEPTH);
    localparam int CW = TW + 1;

    bp_entry_t       q [DEPTH];
    bp_entry_t       h;
    bp_update_t      upd_q;
    logic [TW-1:0]   head, tail;
    logic            retire, mis, need, do_alloc, do_res;

    assign h          = q[head];
    assign retire     = h.valid && h.resolved;
    assign mis        = retire && ((h.pred_valid != h.taken) || (h.taken && h.pred_dest != h.dest));
    assign need       = retire && h.taken && (!h.pred_valid || h.pred_dest != h.dest || h.pred_uncond != h.uncond);
    assign allocReady = count != CW'(DEPTH);
    assign allocTag   = tail;
    assign do_alloc   = allocValid && allocReady && !flush && !mis;
    assign do_res     = resolveValid && q[resolveTag].valid && !q[resolveTag].resolved;
    assign updatePc     = upd_q.pc;
    assign updateDest   = upd_q.dest;
    assign updateUncond = upd_q.uncond;

    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            update        <= 1'b0;
            redirectValid <= 1'b0;
            redirectPc    <= '0;
            upd_q         <= '0;
            for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
        end else if (clkEn) begin
            update        <= need && !flush;
            redirectValid <= mis && !flush;
            if (retire && !flush) begin
                upd_q      <= '{pc: h.pc, dest: h.dest, uncond: h.uncond};
                redirectPc <= h.taken ? h.dest : h.pc + PC_W'(INST_BYTES);
            end
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
                tail  <= head;
                count <= '0;
            end else if (mis) begin
                // younger entries were fetched down the wrong path
                for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
                head  <= head + 1'b1;
                tail  <= head + 1'b1;
                count <= '0;
            end else begin
                if (do_res) begin
                    q[resolveTag].resolved <= 1'b1;
                    q[resolveTag].taken    <= resolveTaken;
                    q[resolveTag].dest     <= resolveDest;
                    q[resolveTag].uncond   <= resolveUncond;
                end
                if (do_alloc) begin
                    q[tail] <= '{pc: allocPc, pred_dest: allocPredDest, pred_valid: allocPredValid,
                                 pred_uncond: allocPredUncond, resolved: 1'b0, taken: 1'b0,
                                 dest: '0, uncond: 1'b0, valid: 1'b1};
                    tail    <= tail + 1'b1;
                end
                if (retire) begin
                    q[head].valid <= 1'b0;
                    head          <= head + 1'b1;
                end
                count <= count + CW'(do_alloc) - CW'(retire);
            end
        end
    end
endmodule

// File: tb/tb_bp_resolver.sv
// tb_bp_resolver: randomized and directed scoreboard bench for bp_resolver against a queue-level reference model
module tb_bp_resolver;
    localparam int D = 8;

    logic        clk = 0, clkEn = 1, rst = 1;
    logic        allocValid = 0, allocPredValid = 0, allocPredUncond = 0;
    logic [63:0] allocPc = 0, allocPredDest = 0, resolveDest = 0;
    logic        resolveValid = 0, resolveTaken = 0, resolveUncond = 0, flush = 0;
    logic [2:0]  resolveTag = 0;
    logic        allocReady, update, updateUncond, redirectValid;
    logic [2:0]  allocTag;
    logic [63:0] updatePc, updateDest, redirectPc;
    logic [3:0]  count;

    bp_resolver #(.DEPTH(D), .INST_BYTES(4)) dut (
        .clk(clk), .clkEn(clkEn), .rst(rst),
        .allocValid(allocValid), .allocReady(allocReady), .allocPc(allocPc),
        .allocPredDest(allocPredDest), .allocPredValid(allocPredValid),
        .allocPredUncond(allocPredUncond), .allocTag(allocTag),
        .resolveValid(resolveValid), .resolveTag(resolveTag), .resolveTaken(resolveTaken),
        .resolveUncond(resolveUncond), .resolveDest(resolveDest), .flush(flush),
        .update(update), .updatePc(updatePc), .updateDest(updateDest),
        .updateUncond(updateUncond), .redirectValid(redirectValid),
        .redirectPc(redirectPc), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc, pd, d;
        bit          pv, pu, res, tk, un;
    } ent_t;
    typedef struct {
        bit          u, r, uu;
        logic [63:0] upc, ud, rpc;
    } exp_t;

    ent_t mq[$];
    exp_t exp_q[$];
    int   hm = 0;
    bit   mu = 0, mr = 0, fresh = 0, rst_seen = 0;
    int   tests = 0, fails = 0;

    // Reference: program-order list of outstanding predictions; tag = (head + position) mod D
    always @(posedge clk) begin : model
        int   n, idx;
        bit   ret, mis, need;
        ent_t e;
        fresh    = 0;
        rst_seen = rst;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            hm = 0; mu = 0; mr = 0;
        end else if (clkEn) begin
            n = mq.size(); ret = 0; mis = 0; need = 0; mu = 0; mr = 0;
            if (flush) mq.delete();
            else begin
                if (n > 0 && mq[0].res) begin
                    e    = mq[0];
                    ret  = 1;
                    mis  = (e.pv != e.tk) || (e.tk && e.pd != e.d);
                    need = e.tk && (!e.pv || e.pd != e.d || e.pu != e.un);
                    mu   = need;
                    mr   = mis;
                    if (need || mis) begin
                        exp_q.push_back('{u: need, r: mis, uu: e.un, upc: e.pc, ud: e.d,
                                          rpc: e.tk ? e.d : e.pc + 64'd4});
                        fresh = 1;
                    end
                end
                if (mis) begin
                    mq.delete();
                    hm = (hm + 1) % D;
                end else begin
                    if (resolveValid) begin
                        idx = (int'(resolveTag) - hm + D) % D;
                        if (idx < n && !mq[idx].res) begin
                            mq[idx].res = 1; mq[idx].tk = resolveTaken;
                            mq[idx].d = resolveDest; mq[idx].un = resolveUncond;
                        end
                    end
                    if (ret) begin
                        void'(mq.pop_front());
                        hm = (hm + 1) % D;
                    end
                    if (allocValid && n < D)
                        mq.push_back('{pc: allocPc, pd: allocPredDest, d: 64'd0, pv: allocPredValid,
                                       pu: allocPredUncond, res: 0, tk: 0, un: 0});
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        chk("count", 64'(count), 64'(mq.size()));
        chk("allocReady", 64'(allocReady), 64'(mq.size() != D));
        chk("allocTag", 64'(allocTag), 64'((hm + mq.size()) % D));
        chk("update", 64'(update), 64'(mu));
        chk("redirectValid", 64'(redirectValid), 64'(mr));
        if (rst_seen) begin
            chk("rst updatePc", updatePc, 64'd0);
            chk("rst redirectPc", redirectPc, 64'd0);
        end
        if (fresh) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL scoreboard: pulse expected but queue empty");
            end else begin
                e = exp_q.pop_front();
                if (e.u) begin
                    chk("updatePc", updatePc, e.upc);
                    chk("updateDest", updateDest, e.ud);
                    chk("updateUncond", 64'(updateUncond), 64'(e.uu));
                end
                if (e.r) chk("redirectPc", redirectPc, e.rpc);
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        allocValid = 0; resolveValid = 0; flush = 0;
    endtask

    task automatic a(input logic [63:0] pc, input logic [63:0] pd, input bit pv, input bit pu, output int t);
        t = (hm + mq.size()) % D;
        allocValid = 1; allocPc = pc; allocPredDest = pd; allocPredValid = pv; allocPredUncond = pu;
        tick();
    endtask

    task automatic r(input int t, input bit tk, input logic [63:0] d, input bit un);
        resolveValid = 1; resolveTag = 3'(t); resolveTaken = tk; resolveDest = d; resolveUncond = un;
        tick();
    endtask

    // resolves outstanding entries with their predicted outcome so they retire cleanly
    task automatic drain;
        repeat (40) begin
            int k = -1;
            for (int i = 0; i < mq.size(); i++) if (k < 0 && !mq[i].res) k = i;
            if (k >= 0) r((hm + k) % D, mq[k].pv, mq[k].pd, mq[k].pu);
            else tick();
        end
    endtask

    logic [63:0] pool [4] = '{64'h2000, 64'h3000, 64'h4000, 64'h0};

    initial begin
        int t0, t1, t2;
        tick(); tick();
        rst = 0;
        tick();
        a(64'h1000, 64'h0, 0, 0, t0); r(t0, 1, 64'h2000, 1); repeat (3) tick();
        a(64'h1000, 64'h2000, 1, 0, t0); r(t0, 1, 64'h2000, 0); repeat (3) tick();
        a(64'h1000, 64'h1800, 1, 0, t0); a(64'h1100, 64'h3000, 1, 0, t1); a(64'h1200, 64'h0, 0, 0, t2);
        r(t2, 0, 64'h0, 0); r(t1, 0, 64'h0, 0); r(t0, 1, 64'h1800, 0); repeat (4) tick();
        for (int i = 0; i < D; i++) a(64'h5000 + 64'(i * 4), 64'h4000, 1, 0, t0);
        r(hm, 1, 64'h4000, 0);
        a(64'h6000, 64'h4000, 1, 0, t0);
        a(64'h6004, 64'h4000, 1, 0, t0);
        drain();
        a(64'h7000, 64'h0, 0, 0, t0); a(64'h7004, 64'h0, 0, 0, t1); a(64'h7008, 64'h0, 0, 0, t2);
        flush = 1; tick();
        r(t1, 1, 64'h9000, 1); repeat (3) tick();
        a(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 0, t0); r(t0, 0, 64'h0, 0);
        clkEn = 0; repeat (3) tick();
        clkEn = 1; repeat (2) tick();
        a(64'h8000, 64'h0, 0, 0, t0); a(64'h8004, 64'h0, 0, 0, t1); r(t0, 1, 64'hA000, 0);
        clkEn = 0; tick(); rst = 1; tick(); rst = 0; clkEn = 1; repeat (2) tick();
        repeat (3000) begin
            clkEn = ($urandom % 8) != 0;
            rst   = ($urandom % 300) == 0;
            flush = ($urandom % 80) == 0;
            if ($urandom % 3 != 0) begin
                allocValid = 1;
                allocPc = ($urandom % 16 == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
                allocPredDest = pool[$urandom % 4]; allocPredValid = $urandom % 2; allocPredUncond = $urandom % 2;
            end
            if ($urandom % 3 != 0) begin
                int k = (mq.size() > 0 && $urandom % 4 != 0) ? int'($urandom % mq.size()) : -1;
                resolveValid = 1;
                resolveTag   = (k >= 0) ? 3'((hm + k) % D) : 3'($urandom);
                resolveTaken = $urandom % 2; resolveDest = pool[$urandom % 4]; resolveUncond = $urandom % 2;
                if (k >= 0 && $urandom % 2 == 0) begin
                    resolveTaken = mq[k].pv; resolveDest = mq[k].pd; resolveUncond = mq[k].pu;
                end
            end
            tick();
            rst = 0;
        end
        clkEn = 1;
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
